// File: rtl/adder_16bit.sv
// adder_16bit -- 16-bit unsigned adder with carry-in/carry-out plus a
// registered copy of the result.
//
// The sum path is purely combinational. It is built as two 8-bit
// carry-lookahead blocks, and each block is made of two 4-bit
// generate/propagate groups. The carry out of the low byte feeds the
// carry in of the high byte.
//
// The registered copy lives on clk/rst_n and does not feed back into the
// sum, so y/Co stay valid even when clk/rst_n are left undriven.
//
// Ports:
//   clk   in   1   rising-edge clock, registered copy only
//   rst_n in   1   async active-low reset, registered copy only
//   a     in  16   operand A, unsigned
//   b     in  16   operand B, unsigned
//   Cin   in   1   carry-in
//   y     out 16   combinational sum [15:0]
//   Co    out  1   combinational carry-out (sum bit 16)
//   y_q   out 16   y registered (one-cycle latency)
//   co_q  out  1   Co registered (one-cycle latency)

// 4-bit lookahead group: sum bits plus group generate/propagate.
module adder_16bit_cla4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] s_o,
    output logic       g_o,
    output logic       p_o
);
    logic [3:0] g, p, c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Every carry is expanded from cin, so no carry depends on the carry below it.
    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & cin_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin_i);

    assign s_o = p ^ c;
    assign g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
    assign p_o = &p;
endmodule

// 8-bit lookahead block: two 4-bit groups joined by second-level lookahead.
module adder_16bit_cla8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] s_o,
    output logic       cout_o
);
    logic [1:0] gg, gp;
    logic [2:0] gc;

    assign gc[0] = cin_i;
    assign gc[1] = gg[0] | (gp[0] & cin_i);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin_i);

    for (genvar k = 0; k < 2; k++) begin : g_grp
        adder_16bit_cla4 u_grp (
            .a_i   (a_i[4*k +: 4]),
            .b_i   (b_i[4*k +: 4]),
            .cin_i (gc[k]),
            .s_o   (s_o[4*k +: 4]),
            .g_o   (gg[k]),
            .p_o   (gp[k])
        );
    end

    assign cout_o = gc[2];
endmodule

module adder_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        Cin,
    output logic [15:0] y,
    output logic        Co,
    output logic [15:0] y_q,
    output logic        co_q
);
    localparam int NUM_BLK = 2;

    // Byte-level carry chain: bc[0] = Cin, bc[1] = carry out of the low
    // byte, bc[2] = final carry-out.
    logic [NUM_BLK:0] bc;

    assign bc[0] = Cin;

    for (genvar k = 0; k < NUM_BLK; k++) begin : g_blk
        adder_16bit_cla8 u_blk (
            .a_i    (a[8*k +: 8]),
            .b_i    (b[8*k +: 8]),
            .cin_i  (bc[k]),
            .s_o    (y[8*k +: 8]),
            .cout_o (bc[k+1])
        );
    end

    assign Co = bc[NUM_BLK];

    logic [15:0] y_d;
    logic        co_d;

    assign y_d  = y;
    assign co_d = Co;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q  <= 16'h0000;
            co_q <= 1'b0;
        end else begin
            y_q  <= y_d;
            co_q <= co_d;
        end
    end
endmodule

// File: tb/tb_adder_16bit.sv
// Directed and random checks of adder_16bit: combinational sum, byte-carry
// crossing, overflow, and the registered copy with async reset.
module tb_adder_16bit;
    logic        clk;
    logic        rst_n;
    logic [15:0] a, b;
    logic        Cin;
    logic [15:0] y, y_q;
    logic        Co, co_q;

    int n_asrt = 0;
    int n_fail = 0;

    adder_16bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .Cin   (Cin),
        .y     (y),
        .Co    (Co),
        .y_q   (y_q),
        .co_q  (co_q)
    );

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full clock period; returns with clk low, 5 ns after the falling edge.
    task automatic tick();
        clk = 1'b1;
        #5;
        clk = 1'b0;
        #5;
    endtask

    task automatic apply(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
        a = ta;
        b = tb;
        Cin = tc;
        #10;
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [16:0] rexp;

        clk = 1'b0;
        rst_n = 1'b0;
        a = 16'h0000;
        b = 16'h0000;
        Cin = 1'b0;
        #10;

        // Reset takes effect without any clock edge.
        chk("reset_q_noclk", {co_q, y_q}, 17'h00000);

        // Combinational directed vectors.
        chk("zero", {Co, y}, 17'h00000);
        apply(16'hFFFF, 16'h0001, 1'b0);
        chk("ffff_p1", {Co, y}, 17'h10000);
        apply(16'h1234, 16'h4321, 1'b0);
        chk("1234_4321", {Co, y}, 17'h05555);
        apply(16'hFFFF, 16'hFFFF, 1'b1);
        chk("max_cin", {Co, y}, 17'h1FFFF);
        apply(16'h00FF, 16'h0001, 1'b0);
        chk("byte_cross", {Co, y}, 17'h00100);
        apply(16'hFFFF, 16'h0000, 1'b1);
        chk("cin_wrap", {Co, y}, 17'h10000);
        apply(16'h0000, 16'h0000, 1'b1);
        chk("cin_only", {Co, y}, 17'h00001);
        apply(16'h0F0F, 16'h00F1, 1'b0);
        chk("nibble_cross", {Co, y}, 17'h01000);
        apply(16'h8000, 16'h7FFF, 1'b1);
        chk("full_ripple", {Co, y}, 17'h10000);

        // Registers hold 0 through an edge while reset is asserted.
        tick();
        chk("reset_hold_edge", {co_q, y_q}, 17'h00000);

        // Random combinational sweep with clk/rst_n idle.
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rexp = {1'b0, ra} + {1'b0, rb};
            apply(ra, rb, 1'b0);
            chk($sformatf("rand%0d", i), {Co, y}, rexp);
        end

        // Registered path.
        rst_n = 1'b1;
        #10;
        apply(16'h8000, 16'h8000, 1'b0);
        chk("8000_8000", {Co, y}, 17'h10000);
        tick();
        chk("reg_8000_8000", {co_q, y_q}, 17'h10000);

        apply(16'h1234, 16'h4321, 1'b0);
        chk("reg_hold_between", {co_q, y_q}, 17'h10000);
        tick();
        chk("reg_5555", {co_q, y_q}, 17'h05555);

        // Reset between edges clears at once; comb path keeps tracking.
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async_mid", {co_q, y_q}, 17'h00000);
        chk("comb_during_reset", {Co, y}, 17'h05555);
        a = 16'hFFFF;
        b = 16'h0001;
        #10;
        chk("comb_track_reset", {Co, y}, 17'h10000);

        // First edge after release loads the current sum.
        rst_n = 1'b1;
        #5;
        tick();
        chk("reg_after_release", {co_q, y_q}, 17'h10000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
